// File: rtl/spi_ram_pkg.sv
// Shared types and command encodings for the SPI-accessible RAM peripheral.
package spi_ram_pkg;

  localparam int FRAME_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port byte RAM with the command decoder acting on each received frame.
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] rx_data,
  input  logic               rx_valid,
  output logic [7:0]         dout,
  output logic               tx_valid
);

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [1:0]           cmd;

  assign cmd = rx_data[FRAME_W-1:FRAME_W-2];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (rx_valid) begin
        case (cmd)
          CMD_WR_ADDR: wr_addr  <= rx_data[ADDR_SIZE-1:0];
          CMD_RD_ADDR: rd_addr  <= rx_data[ADDR_SIZE-1:0];
          CMD_RD_DATA: tx_valid <= 1'b1;
          default:     ;
        endcase
      end
    end
  end

  // Array and read register carry data only, so they stay out of reset.
  always_ff @(posedge clk) begin
    if (rx_valid && cmd == CMD_WR_DATA) mem[wr_addr] <= rx_data[7:0];
    if (rx_valid && cmd == CMD_RD_DATA) dout <= mem[rd_addr];
  end

endmodule

// File: rtl/spi_ram_wrapper.sv
// SPI slave front-end (clk doubles as SCLK) feeding the on-chip RAM and
// serialising read data back on MISO.
module spi_ram_wrapper
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MOSI,
  input  logic SS_N,
  output logic MISO
);

  state_t             state;
  logic [3:0]         bit_cnt;
  logic [FRAME_W-1:0] shift_reg;
  logic               rx_valid;
  logic               tx_valid;
  logic [7:0]         dout;
  logic               rd_held;
  logic               tx_busy;
  logic [2:0]         tx_cnt;
  logic [6:0]         tx_buf;

  // Frame receive FSM: bit 9 arrives in CHK_CMD, bits 8..0 in the data states.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_N) begin
        state   <= IDLE;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state   <= CHK_CMD;
            bit_cnt <= '0;
          end
          CHK_CMD: begin
            shift_reg <= {shift_reg[FRAME_W-2:0], MOSI};
            bit_cnt   <= 4'd1;
            if (!MOSI)        state <= WRITE;
            else if (rd_held) state <= READ_DATA;
            else              state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            // Extra clocks after a full frame are ignored until SS_N rises.
            if (bit_cnt < 4'(FRAME_W)) begin
              shift_reg <= {shift_reg[FRAME_W-2:0], MOSI};
              bit_cnt   <= bit_cnt + 4'd1;
              if (bit_cnt == 4'(FRAME_W - 1)) rx_valid <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Readback serialiser and read-address-held flag.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      MISO    <= 1'b0;
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      rd_held <= 1'b0;
    end else begin
      if (rx_valid && shift_reg[FRAME_W-1:FRAME_W-2] == CMD_RD_ADDR) rd_held <= 1'b1;
      if (SS_N) begin
        MISO    <= 1'b0;
        tx_busy <= 1'b0;
      end else if (tx_valid && state == READ_DATA) begin
        MISO    <= dout[7];
        tx_buf  <= dout[6:0];
        tx_cnt  <= 3'd7;
        tx_busy <= 1'b1;
      end else if (tx_busy) begin
        if (tx_cnt != 3'd0) begin
          MISO   <= tx_buf[6];
          tx_buf <= {tx_buf[5:0], 1'b0};
          tx_cnt <= tx_cnt - 3'd1;
        end else begin
          MISO    <= 1'b0;
          tx_busy <= 1'b0;
          rd_held <= 1'b0;
        end
      end else begin
        MISO <= 1'b0;
      end
    end
  end

  spi_ram_mem #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (shift_reg),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid)
  );

endmodule

// File: tb/tb_spi_ram_wrapper.sv
// Directed bench for spi_ram_wrapper: frame table plus abort/reset sequences.
module tb_spi_ram_wrapper;
  import spi_ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic MOSI = 1'b0;
  logic SS_N = 1'b1;
  logic MISO;

  int n_vec = 0;
  int n_err = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;

  always #5 clk = ~clk;

  spi_ram_wrapper #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .MOSI  (MOSI),
    .SS_N  (SS_N),
    .MISO  (MISO)
  );

  always @(posedge clk) begin
    if (dut.rx_valid === 1'b1) rx_cnt <= rx_cnt + 1;
    if (dut.u_mem.tx_valid === 1'b1) tx_cnt <= tx_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Lowers SS_N, waits the IDLE->CHK_CMD edge, then shifts nbits MSB first.
  task automatic shift_frame(input logic [9:0] f, input int nbits, output logic miso_seen);
    miso_seen = 1'b0;
    @(negedge clk);
    SS_N = 1'b0;
    @(posedge clk);
    for (int i = 9; i > 9 - nbits; i--) begin
      @(negedge clk);
      MOSI = f[i];
      if (MISO !== 1'b0) miso_seen = 1'b1;
      @(posedge clk);
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    SS_N = 1'b1;
    MOSI = 1'b0;
    @(posedge clk);
  endtask

  task automatic read_back(output logic [7:0] b, output logic tail);
    @(posedge clk);
    for (int i = 7; i >= 0; i--) begin
      @(posedge clk);
      #1;
      b[i] = MISO;
    end
    @(posedge clk);
    #1;
    tail = MISO;
  endtask

  typedef struct {
    logic [9:0] frame;
    bit         rd;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic       seen;
    logic       tail;
    logic [7:0] b;
    int         t0;
    int         r0;

    vecs[0]  = '{10'b00_11111111, 1'b0, 8'h00};
    vecs[1]  = '{10'b01_10101011, 1'b0, 8'h00};
    vecs[2]  = '{10'b10_11111111, 1'b0, 8'h00};
    vecs[3]  = '{10'b11_00000000, 1'b1, 8'hAB};
    vecs[4]  = '{10'b00_00010000, 1'b0, 8'h00};
    vecs[5]  = '{10'b01_00111100, 1'b0, 8'h00};
    vecs[6]  = '{10'b00_00010001, 1'b0, 8'h00};
    vecs[7]  = '{10'b01_11000011, 1'b0, 8'h00};
    vecs[8]  = '{10'b10_00010000, 1'b0, 8'h00};
    vecs[9]  = '{10'b11_00000000, 1'b1, 8'h3C};
    vecs[10] = '{10'b10_00010001, 1'b0, 8'h00};
    vecs[11] = '{10'b11_11111111, 1'b1, 8'hC3};
    vecs[12] = '{10'b10_11111111, 1'b0, 8'h00};
    vecs[13] = '{10'b11_01010101, 1'b1, 8'hAB};

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    check("reset_miso", 32'(MISO), 32'd0);
    check("reset_state", 32'(dut.state), 32'(IDLE));
    check("reset_rx_valid", 32'(dut.rx_valid), 32'd0);
    check("reset_tx_valid", 32'(dut.u_mem.tx_valid), 32'd0);
    check("reset_rd_held", 32'(dut.rd_held), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;

    for (int v = 0; v < 14; v++) begin
      t0 = tx_cnt;
      shift_frame(vecs[v].frame, 10, seen);
      check($sformatf("v%0d_miso_quiet", v), 32'(seen), 32'd0);
      if (vecs[v].rd) begin
        read_back(b, tail);
        check($sformatf("v%0d_readback", v), 32'(b), 32'(vecs[v].exp));
        check($sformatf("v%0d_miso_tail", v), 32'(tail), 32'd0);
        check($sformatf("v%0d_tx_pulses", v), 32'(tx_cnt - t0), 32'd1);
      end else begin
        repeat (2) @(posedge clk);
        #1;
        check($sformatf("v%0d_miso_after", v), 32'(MISO), 32'd0);
        check($sformatf("v%0d_tx_pulses", v), 32'(tx_cnt - t0), 32'd0);
      end
      end_frame();
    end

    check("mem_ff", 32'(dut.u_mem.mem[8'hFF]), 32'h0000_00AB);
    check("mem_10", 32'(dut.u_mem.mem[8'h10]), 32'h0000_003C);
    check("mem_11", 32'(dut.u_mem.mem[8'h11]), 32'h0000_00C3);

    // Abort a write-data frame after 5 bits
    r0 = rx_cnt;
    shift_frame(10'b01_00001111, 5, seen);
    @(negedge clk);
    SS_N = 1'b1;
    MOSI = 1'b0;
    @(posedge clk);
    #1;
    check("abort_state", 32'(dut.state), 32'(IDLE));
    repeat (3) @(posedge clk);
    #1;
    check("abort_rx_valid", 32'(rx_cnt - r0), 32'd0);
    check("abort_mem_11", 32'(dut.u_mem.mem[8'h11]), 32'h0000_00C3);
    check("abort_miso", 32'(MISO), 32'd0);

    // Reset, then write-data with no write-address lands at address 0
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    shift_frame(10'b01_01011010, 10, seen);
    repeat (2) @(posedge clk);
    end_frame();
    check("wr_default_addr", 32'(dut.u_mem.mem[8'h00]), 32'h0000_005A);

    // Read-data with flag clear goes to READ_ADD and reads rd_addr 0
    t0 = tx_cnt;
    shift_frame(10'b11_11110000, 10, seen);
    check("rd_noflag_state", 32'(dut.state), 32'(READ_ADD));
    repeat (3) @(posedge clk);
    #1;
    check("rd_noflag_tx", 32'(tx_cnt - t0), 32'd1);
    check("rd_noflag_dout", 32'(dut.u_mem.dout), 32'h0000_005A);
    end_frame();

    // Reset in the middle of a readback of 0x5A
    shift_frame(10'b10_00000000, 10, seen);
    repeat (2) @(posedge clk);
    end_frame();
    shift_frame(10'b11_00000000, 10, seen);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midrd_bit7", 32'(MISO), 32'd0);
    @(posedge clk);
    #1;
    check("midrd_bit6", 32'(MISO), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrd_rst_miso", 32'(MISO), 32'd0);
    check("midrd_rst_state", 32'(dut.state), 32'(IDLE));
    check("midrd_rst_flag", 32'(dut.rd_held), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    SS_N = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_ram_wrapper.md
Name: spi_ram_wrapper

Overview:
- SPI slave front-end combined with an on-chip single-port RAM, clocked by one system clock. SCLK is not a separate input: `clk` is the serial clock.
- An external master frames transactions with `SS_N`, shifts 10-bit command words in on `MOSI`, and receives 8-bit read data on `MISO`.
- The block is the top-level SPI-accessible memory peripheral.

Parameters:
- MEM_DEPTH, 256, number of RAM words; each word is 8 bits.
- ADDR_SIZE, 8, address width in bits. The frame payload width equals ADDR_SIZE. MEM_DEPTH must equal 2**ADDR_SIZE.

Ports:
- clk  input  1  system/serial clock; all logic acts on the rising edge.
- rst_n  input  1  synchronous reset, active-high. The name is kept for codebase consistency; asserting it to 1 resets the block.
- MOSI  input  1  serial data from master, MSB first, sampled on rising clk.
- SS_N  input  1  slave select, active-low; 1 aborts or ends a frame.
- MISO  output  1  serial read data to master, MSB first.

Behaviour:
- Frame format: 10 bits, MSB first.
  - Bits [9:8] are the command; bits [7:0] are the payload.
  - Commands: 00 = write address, 01 = write data, 10 = read address, 11 = read data.
- Reset (rst_n=1 at a rising edge):
  - state=IDLE, bit counter=0, shift register=0, rx_valid=0, tx_valid=0, MISO=0.
  - Latched write and read addresses = 0; read-address-held flag = 0.
  - RAM contents are not cleared.
  - Reset mid-frame discards the partial frame.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- Transitions:
  - IDLE -> CHK_CMD when SS_N=0.
  - CHK_CMD on MOSI=0 -> WRITE.
  - CHK_CMD on MOSI=1 -> READ_ADD if the read-address-held flag is 0, else READ_DATA.
  - Any state -> IDLE when SS_N=1 is sampled.
  - A frame aborted by SS_N=1 produces no rx_valid and no RAM access.
- Shifting:
  - The MOSI bit sampled in CHK_CMD is captured as frame bit 9.
  - Bits 8..0 are sampled on the next 9 rising edges.
  - 10 consecutive edges in total, shifted in MSB first.
- rx_valid:
  - Pulses high for exactly one cycle, on the cycle after frame bit 0 is sampled.
  - rx_data[9:0] is stable while rx_valid is high.
- RAM actions on rx_valid:
  - cmd 00: wr_addr <= payload.
  - cmd 01: RAM[wr_addr] <= payload.
  - cmd 10: rd_addr <= payload; read-address-held flag <= 1.
  - cmd 11: payload is a don't-care. dout <= RAM[rd_addr] and tx_valid pulses for 1 cycle, on the cycle after rx_valid.
  - The RAM decodes bits [9:8] regardless of which state captured the frame.
- READ_DATA readback:
  - On tx_valid the slave loads dout.
  - dout[7] is driven on MISO on the first rising edge after tx_valid, followed by dout[6]..dout[0] on the next 7 edges.
  - After bit 0, MISO returns to 0 and the read-address-held flag clears.
  - The state stays READ_DATA until SS_N=1.
- MISO is 0 whenever no readback is in progress.
- SS_N rising during readback aborts it: MISO=0 and the flag is retained.
- The master keeps SS_N low for the entire frame, including readback. SS_N must be high for at least 1 cycle between frames.
- Write-data with no prior write-address uses wr_addr=0.
- A new cmd 10 overwrites rd_addr.

Decomposition:
- Package spi_ram_pkg: state enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA) and command localparams (CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11).
- Sub-module spi_ram_mem: MEM_DEPTH x 8 array plus the command decoder; inputs rx_data[9:0] and rx_valid; outputs dout[7:0] and tx_valid.
- The wrapper holds the slave FSM, shift register and counter, and instantiates spi_ram_mem.

Test Plan:
- Reset: hold rst_n=1 for 2 cycles -> MISO=0, state=IDLE, rx_valid=0.
- Write frames 00_11111111 then 01_10101011 -> RAM[0xFF]=0xAB; MISO stays 0 throughout.
- Read frames 10_11111111 then 11_00000000 -> tx_valid pulses once; MISO shows 1,0,1,0,1,0,1,1 (0xAB MSB first) on 8 consecutive edges, then 0.
- Abort: SS_N=1 after 5 bits of 01_00001111 -> no rx_valid; RAM[wr_addr] unchanged; state=IDLE next cycle.
- Read-data without a read address (flag=0): frame 11_xxxxxxxx enters READ_ADD; a subsequent read uses rd_addr=0 -> MISO shows RAM[0x00].
- Reset asserted mid-readback -> MISO=0 immediately after the edge; state=IDLE; flag=0.
